// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, data} entries with synchronous flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fetch_entry_t           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  fetch_entry_t  entries [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Flush outranks both push and pop so a redirect never lets a stale word in.
  assign do_push = push && !flush;
  assign do_pop  = pop && (count_reg != '0) && !flush;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    fetch_entry_t entry_reg;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        entry_reg <= '0;
      end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
        entry_reg <= push_entry;
      end
    end

    assign entries[gi] = entry_reg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != '0);
  assign head       = entries[rd_ptr_reg];

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch controller: one outstanding imem fetch, buffered words to decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_killed counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   req_pc_reg, req_pc_next;
  logic          kill_reg, kill_next;
  logic          push;
  logic          pop;
  logic          flush;
  logic          discard;
  logic [CW-1:0] count;
  logic          head_valid;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
      kill_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_pc_reg <= req_pc_next;
      kill_reg   <= kill_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    kill_next   = kill_reg;
    imem_req    = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    discard     = 1'b0;
    case (state_reg)
      IDLE: state_next = ISSUE;
      ISSUE: begin
        // Only request when the returning word is guaranteed a buffer slot.
        imem_req = (count < CW'(BUF_DEPTH));
        if (redirect_valid) begin
          pc_next = align_pc(redirect_pc);
          flush   = 1'b1;
          if (imem_req && imem_gnt) begin
            kill_next  = 1'b1;
            state_next = WAIT;
          end
        end else if (imem_req && imem_gnt) begin
          req_pc_next = pc_reg;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_next = align_pc(redirect_pc);
          flush   = 1'b1;
          if (imem_rvalid) begin
            discard    = 1'b1;
            kill_next  = 1'b0;
            state_next = ISSUE;
          end else begin
            kill_next = 1'b1;
          end
        end else if (imem_rvalid) begin
          state_next = ISSUE;
          if (kill_reg) begin
            discard   = 1'b1;
            kill_next = 1'b0;
          end else begin
            push    = 1'b1;
            pc_next = req_pc_reg + 32'(INSTR_BYTES);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign push_entry = '{pc: req_pc_reg, data: imem_rdata};
  assign pop        = head_valid && inst_ready;

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign imem_addr  = pc_reg;
  assign inst_valid = head_valid;
  assign inst_data  = head_valid ? head.data : 32'h0;
  assign inst_pc    = head_valid ? head.pc : 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_killed_reg;
  logic [31:0] flushed_cnt;

  // A head accepted by decode in the redirect cycle counts as delivered, not killed.
  assign flushed_cnt = flush ? (32'(count) - 32'(pop)) : 32'h0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_reg <= 32'h0;
      perf_killed_reg  <= 32'h0;
    end else begin
      perf_fetched_reg <= perf_fetched_reg + 32'(push);
      perf_killed_reg  <= perf_killed_reg + flushed_cnt + 32'(discard);
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_killed  = perf_killed_reg;
`endif

endmodule
